// File: rtl/s_stream_feeder.sv
// s_stream_feeder: buffers 2-bit query bases and serves them to the array
// as packed chunks of up to PE_SIZE bases on request. Holds one sequence at
// a time; the final partial chunk is released only after i_base_last.
module s_stream_feeder #(
  parameter int PE_SIZE     = 64,
  parameter int PE_SIZE_LOG = 6,
  parameter int FIFO_DEPTH  = 128,
  parameter int FIFO_LOG    = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             i_base,
  input  logic                   i_base_valid,
  input  logic                   i_base_last,
  output logic                   o_base_ready,
  input  logic                   i_flush,
  input  logic                   i_request_s,
  output logic [2*PE_SIZE-1:0]   o_s,
  output logic [PE_SIZE_LOG:0]   o_s_valid,
  output logic                   o_seq_done,
  output logic [FIFO_LOG:0]      o_fifo_count
);

  typedef enum logic {
    LOAD,
    DRAIN
  } state_t;

  localparam logic [FIFO_LOG:0] PE_CNT    = (FIFO_LOG+1)'(PE_SIZE);
  localparam logic [FIFO_LOG:0] DEPTH_CNT = (FIFO_LOG+1)'(FIFO_DEPTH);

  state_t                state;
  state_t                state_next;
  logic [1:0]            mem [FIFO_DEPTH];
  logic [FIFO_LOG-1:0]   rd_ptr;
  logic [FIFO_LOG-1:0]   wr_ptr;
  logic [FIFO_LOG-1:0]   idx;
  logic [FIFO_LOG:0]     cnt;
  logic [FIFO_LOG:0]     cnt_next;
  logic [FIFO_LOG:0]     n_cnt;
  logic                  pend;
  logic                  req_eff;
  logic                  wr;
  logic                  emit;
  logic                  seq_done_next;
  logic [2*PE_SIZE-1:0]  chunk;

  assign o_base_ready = (state == LOAD) && (cnt < DEPTH_CNT) && !i_flush;
  assign wr           = i_base_valid && o_base_ready;
  assign req_eff      = pend || i_request_s;
  assign n_cnt        = (cnt >= PE_CNT) ? PE_CNT : cnt;
  // A partial chunk is only released once the sequence end has been seen.
  assign emit         = req_eff && !i_flush &&
                        ((cnt >= PE_CNT) || ((state == DRAIN) && (cnt != '0)));
  assign cnt_next     = cnt + {{FIFO_LOG{1'b0}}, wr} - (emit ? n_cnt : '0);
  assign o_fifo_count = cnt;

  // Gather the oldest n_cnt bases into a zero-padded chunk.
  always_comb begin
    chunk = '0;
    idx   = '0;
    for (int unsigned k = 0; k < PE_SIZE; k++) begin
      idx = rd_ptr + FIFO_LOG'(k);
      if ((FIFO_LOG+1)'(k) < n_cnt) begin
        chunk[2*k +: 2] = mem[idx];
      end
    end
  end

  // Next-state logic: LOAD until the last base lands, DRAIN until emptied.
  always_comb begin
    state_next    = state;
    seq_done_next = 1'b0;
    if (i_flush) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (wr && i_base_last) begin
            state_next = DRAIN;
          end
        end
        DRAIN: begin
          if (emit && (cnt == n_cnt)) begin
            state_next    = LOAD;
            seq_done_next = 1'b1;
          end
        end
        default: state_next = LOAD;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Base storage; contents need no reset since cnt gates every read.
  always_ff @(posedge clk) begin
    if (wr) begin
      mem[wr_ptr] <= i_base;
    end
  end

  // Pointers, occupancy, pending request and registered chunk outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      o_s        <= '0;
      o_s_valid  <= '0;
      o_seq_done <= 1'b0;
    end else if (i_flush) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      cnt        <= '0;
      pend       <= 1'b0;
      o_s        <= '0;
      o_s_valid  <= '0;
      o_seq_done <= 1'b0;
    end else begin
      if (wr) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (emit) begin
        rd_ptr <= rd_ptr + n_cnt[FIFO_LOG-1:0];
      end
      cnt        <= cnt_next;
      pend       <= emit ? 1'b0 : req_eff;
      o_s        <= emit ? chunk : '0;
      o_s_valid  <= emit ? (PE_SIZE_LOG+1)'(n_cnt) : '0;
      o_seq_done <= seq_done_next;
    end
  end

endmodule

// File: tb/tb_s_stream_feeder.sv
// Directed bench for s_stream_feeder: inputs driven and outputs sampled on
// the falling edge, so every sample reflects the preceding rising edge.
module tb_s_stream_feeder;

  logic         clk;
  logic         rst_n;
  logic [1:0]   base;
  logic         base_valid;
  logic         base_last;
  logic         base_ready;
  logic         flush;
  logic         request_s;
  logic [127:0] s;
  logic [6:0]   s_valid;
  logic         seq_done;
  logic [7:0]   fifo_count;

  int checks;
  int errors;

  s_stream_feeder #(
    .PE_SIZE     (64),
    .PE_SIZE_LOG (6),
    .FIFO_DEPTH  (128),
    .FIFO_LOG    (7)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_base       (base),
    .i_base_valid (base_valid),
    .i_base_last  (base_last),
    .o_base_ready (base_ready),
    .i_flush      (flush),
    .i_request_s  (request_s),
    .o_s          (s),
    .o_s_valid    (s_valid),
    .o_seq_done   (seq_done),
    .o_fifo_count (fifo_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // pat 0: base k = k%4 (bytes 8'hE4); pat 1: base k = 3-k%4 (bytes 8'h1B)
  task automatic push(input int n, input int pat, input bit last);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      base_valid = 1'b1;
      base       = (pat != 0) ? 2'(3 - (k % 4)) : 2'(k % 4);
      base_last  = last && (k == n - 1);
    end
    @(negedge clk);
    base_valid = 1'b0;
    base_last  = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (fifo_count !== 8'd0 || s_valid !== 7'd0 || seq_done !== 1'b0 || s !== '0) begin
      errors++;
      $display("FAIL reset_outputs: count=%0d valid=%0d done=%b s=%h, required 0/0/0/0",
               fifo_count, s_valid, seq_done, s);
    end
    checks++;
    if (base_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: got %b, required 1", base_ready);
    end
    rst_n = 1'b1;
    push(5, 0, 1'b0);
    request_s = 1'b1;
    @(negedge clk);
    request_s = 1'b0;
    checks++;
    if (fifo_count !== 8'd5 || s_valid !== 7'd0) begin
      errors++;
      $display("FAIL pre_reset_fill: count=%0d valid=%0d, required 5/0", fifo_count, s_valid);
    end
    base_valid = 1'b1;
    base       = 2'd2;
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (fifo_count !== 8'd0 || s_valid !== 7'd0 || base_ready !== 1'b1) begin
      errors++;
      $display("FAIL midstream_reset: count=%0d valid=%0d ready=%b, required 0/0/1",
               fifo_count, s_valid, base_ready);
    end
    base_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_count !== 8'd0 || base_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_release: count=%0d ready=%b, required 0/1", fifo_count, base_ready);
    end
  endtask

  task automatic test_full_chunk();
    push(64, 0, 1'b0);
    checks++;
    if (fifo_count !== 8'd64 || s_valid !== 7'd0) begin
      errors++;
      $display("FAIL chunk_prefill: count=%0d valid=%0d, required 64/0", fifo_count, s_valid);
    end
    request_s = 1'b1;
    @(negedge clk);
    request_s = 1'b0;
    checks++;
    if (s_valid !== 7'd64 || s[1:0] !== 2'd0 || s[7:6] !== 2'd3 || s !== {16{8'hE4}}) begin
      errors++;
      $display("FAIL full_chunk: valid=%0d s=%h, required 64 and %h", s_valid, s, {16{8'hE4}});
    end
    checks++;
    if (fifo_count !== 8'd0 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL full_chunk_count: count=%0d done=%b, required 0/0", fifo_count, seq_done);
    end
    @(negedge clk);
    checks++;
    if (s_valid !== 7'd0 || s !== '0) begin
      errors++;
      $display("FAIL chunk_one_cycle: valid=%0d s=%h, required 0/0", s_valid, s);
    end
  endtask

  task automatic test_partial_last();
    logic [127:0] exp;
    exp = '0;
    exp[19:0] = 20'h4E4E4;
    push(10, 0, 1'b1);
    checks++;
    if (base_ready !== 1'b0 || fifo_count !== 8'd10 || s_valid !== 7'd0) begin
      errors++;
      $display("FAIL drain_ready: ready=%b count=%0d valid=%0d, required 0/10/0",
               base_ready, fifo_count, s_valid);
    end
    request_s = 1'b1;
    @(negedge clk);
    request_s = 1'b0;
    checks++;
    if (s_valid !== 7'd10 || s !== exp || seq_done !== 1'b1) begin
      errors++;
      $display("FAIL partial_chunk: valid=%0d s=%h done=%b, required 10 %h 1",
               s_valid, s, seq_done, exp);
    end
    checks++;
    if (fifo_count !== 8'd0 || base_ready !== 1'b1) begin
      errors++;
      $display("FAIL partial_after: count=%0d ready=%b, required 0/1", fifo_count, base_ready);
    end
    @(negedge clk);
    checks++;
    if (seq_done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse: got %b, required 0", seq_done);
    end
  endtask

  task automatic test_wait_request();
    int early;
    int extra;
    early = 0;
    extra = 0;
    @(negedge clk);
    request_s = 1'b1;
    @(negedge clk);
    request_s = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (s_valid !== 7'd0) early++;
      base_valid = 1'b1;
      base       = 2'(k % 4);
      request_s  = (k == 30);
    end
    @(negedge clk);
    base_valid = 1'b0;
    request_s  = 1'b0;
    checks++;
    if (early != 0 || s_valid !== 7'd0 || fifo_count !== 8'd64) begin
      errors++;
      $display("FAIL wait_no_early: early=%0d valid=%0d count=%0d, required 0/0/64",
               early, s_valid, fifo_count);
    end
    @(negedge clk);
    checks++;
    if (s_valid !== 7'd64 || s !== {16{8'hE4}} || fifo_count !== 8'd0) begin
      errors++;
      $display("FAIL wait_chunk: valid=%0d count=%0d s=%h, required 64/0 %h",
               s_valid, fifo_count, s, {16{8'hE4}});
    end
    push(64, 0, 1'b0);
    if (s_valid !== 7'd0) extra++;
    repeat (3) begin
      @(negedge clk);
      if (s_valid !== 7'd0) extra++;
    end
    checks++;
    if (extra != 0 || fifo_count !== 8'd64) begin
      errors++;
      $display("FAIL no_queued_request: extra=%0d count=%0d, required 0/64", extra, fifo_count);
    end
  endtask

  task automatic test_full_wrap();
    push(64, 1, 1'b0);
    checks++;
    if (base_ready !== 1'b0 || fifo_count !== 8'd128) begin
      errors++;
      $display("FAIL full_ready: ready=%b count=%0d, required 0/128", base_ready, fifo_count);
    end
    request_s  = 1'b1;
    base_valid = 1'b1;
    base       = 2'd2;
    @(negedge clk);
    checks++;
    if (s_valid !== 7'd64 || s !== {16{8'hE4}} || fifo_count !== 8'd64 || base_ready !== 1'b1) begin
      errors++;
      $display("FAIL full_pop: valid=%0d count=%0d ready=%b s=%h, required 64/64/1 %h",
               s_valid, fifo_count, base_ready, s, {16{8'hE4}});
    end
    @(negedge clk);
    request_s  = 1'b0;
    base_valid = 1'b0;
    checks++;
    if (s_valid !== 7'd64 || s !== {16{8'h1B}} || fifo_count !== 8'd1) begin
      errors++;
      $display("FAIL wrap_write_pop: valid=%0d count=%0d s=%h, required 64/1 %h",
               s_valid, fifo_count, s, {16{8'h1B}});
    end
  endtask

  task automatic test_multi_and_flush();
    logic [127:0] exp;
    int stray;
    exp = '0;
    exp[71:0] = {9{8'hE4}};
    stray = 0;
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (fifo_count !== 8'd0 || s_valid !== 7'd0) begin
      errors++;
      $display("FAIL flush_residual: count=%0d valid=%0d, required 0/0", fifo_count, s_valid);
    end
    push(100, 0, 1'b1);
    request_s = 1'b1;
    @(negedge clk);
    request_s = 1'b0;
    checks++;
    if (s_valid !== 7'd64 || seq_done !== 1'b0 || fifo_count !== 8'd36 || s !== {16{8'hE4}}) begin
      errors++;
      $display("FAIL multi_first: valid=%0d done=%b count=%0d, required 64/0/36",
               s_valid, seq_done, fifo_count);
    end
    @(negedge clk);
    request_s = 1'b1;
    checks++;
    if (s_valid !== 7'd0) begin
      errors++;
      $display("FAIL multi_gap: valid=%0d, required 0", s_valid);
    end
    @(negedge clk);
    request_s = 1'b0;
    checks++;
    if (s_valid !== 7'd36 || seq_done !== 1'b1 || s !== exp || fifo_count !== 8'd0) begin
      errors++;
      $display("FAIL multi_last: valid=%0d done=%b count=%0d s=%h, required 36/1/0 %h",
               s_valid, seq_done, fifo_count, s, exp);
    end
    push(20, 0, 1'b0);
    flush      = 1'b1;
    request_s  = 1'b1;
    base_valid = 1'b1;
    base       = 2'd3;
    @(negedge clk);
    flush      = 1'b0;
    request_s  = 1'b0;
    base_valid = 1'b0;
    checks++;
    if (fifo_count !== 8'd0 || s_valid !== 7'd0 || seq_done !== 1'b0) begin
      errors++;
      $display("FAIL flush_mid: count=%0d valid=%0d done=%b, required 0/0/0",
               fifo_count, s_valid, seq_done);
    end
    push(64, 0, 1'b0);
    if (s_valid !== 7'd0) stray++;
    repeat (2) begin
      @(negedge clk);
      if (s_valid !== 7'd0) stray++;
    end
    checks++;
    if (stray != 0 || fifo_count !== 8'd64) begin
      errors++;
      $display("FAIL flush_drops_request: stray=%0d count=%0d, required 0/64", stray, fifo_count);
    end
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b0;
    base       = 2'd0;
    base_valid = 1'b0;
    base_last  = 1'b0;
    flush      = 1'b0;
    request_s  = 1'b0;
    test_reset();
    test_full_chunk();
    test_partial_last();
    test_wait_request();
    test_full_wrap();
    test_multi_and_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
